// File: rtl/addf_arbiter.sv
// Round-robin arbiter sharing one combinational FP32 adder among N requesters.
// Operands are latched at grant, the sum is registered one cycle later.
module addf_arbiter #(
   parameter int N = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic [N-1:0]    sub,
   input  logic [32*N-1:0] a,
   input  logic [32*N-1:0] b,
   output logic [N-1:0]    gnt,
   output logic [N-1:0]    rvalid,
   output logic [31:0]     result,
   output logic            busy
);

   localparam int PW = (N > 2) ? 2 : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [PW-1:0]   owner_q, owner_d;
   logic [31:0]     opa_q, opa_d;
   logic [31:0]     opb_q, opb_d;
   logic [31:0]     result_q, result_d;
   logic [N-1:0]    gnt_q, gnt_d;
   logic [N-1:0]    rvalid_q, rvalid_d;
   logic            found;
   logic [PW-1:0]   win;
   logic [PW-1:0]   cand;
   logic [31:0]     sel_a, sel_b;
   logic            sel_sub;

   // IEEE-754 single add, round-to-nearest-even; NaN/inf pass straight through.
   function automatic logic [31:0] addf(input logic [31:0] x_in, input logic [31:0] y_in);
      logic [31:0] x, y, r;
      logic [7:0]  ex, ey, d;
      logic [23:0] mx, my;
      logic [52:0] wide;
      logic [26:0] xs, ys;
      logic [27:0] s;
      logic [9:0]  e, sh;
      logic [4:0]  lz;
      logic        lz_found;
      logic [24:0] m;
      if (x_in[30:23] == 8'hFF || y_in[30:23] == 8'hFF) begin
         if (x_in[30:23] == 8'hFF && x_in[22:0] != 23'd0)      r = x_in;
         else if (y_in[30:23] == 8'hFF && y_in[22:0] != 23'd0) r = y_in;
         else if (x_in[30:23] == 8'hFF && y_in[30:23] == 8'hFF && x_in[31] != y_in[31])
            r = 32'h7FC0_0000;
         else if (x_in[30:23] == 8'hFF) r = x_in;
         else r = y_in;
      end else begin
         if (x_in[30:0] >= y_in[30:0]) begin x = x_in; y = y_in; end
         else begin x = y_in; y = x_in; end
         ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
         ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
         mx = {x[30:23] != 8'd0, x[22:0]};
         my = {y[30:23] != 8'd0, y[22:0]};
         d  = ex - ey;
         wide = {my, 29'd0} >> ((d > 8'd29) ? 8'd29 : d);
         ys = {wide[52:27], wide[26] | (|wide[25:0])};
         xs = {mx, 3'b000};
         if (x[31] == y[31]) s = {1'b0, xs} + {1'b0, ys};
         else                s = {1'b0, xs} - {1'b0, ys};
         e = {2'b00, ex};
         if (s == 28'd0) begin
            r = {x[31] & y[31], 31'd0};
         end else begin
            if (s[27]) begin
               s = {1'b0, s[27:2], s[1] | s[0]};
               e = e + 10'd1;
            end else begin
               lz = 5'd0;
               lz_found = 1'b0;
               for (int i = 26; i >= 0; i--) begin
                  if (!lz_found) begin
                     if (s[i]) lz_found = 1'b1;
                     else      lz = lz + 5'd1;
                  end
               end
               // Stop at the denormal boundary rather than underflowing the exponent.
               sh = ({5'd0, lz} < e) ? {5'd0, lz} : e - 10'd1;
               s  = s << sh;
               e  = e - sh;
            end
            m = {1'b0, s[26:3]} + {24'd0, s[2] & (s[1] | s[0] | s[3])};
            if (m[24]) begin
               m = m >> 1;
               e = e + 10'd1;
            end
            if (e >= 10'd255) r = {x[31], 8'hFF, 23'd0};
            else              r = {x[31], m[23] ? e[7:0] : 8'd0, m[22:0]};
         end
      end
      return r;
   endfunction

   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int i = 0; i < N; i++) begin
         cand = PW'((int'(ptr_q) + i) % N);
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
      sel_a   = '0;
      sel_b   = '0;
      sel_sub = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (win == PW'(k)) begin
            sel_a   = a[32*k +: 32];
            sel_b   = b[32*k +: 32];
            sel_sub = sub[k];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      owner_d  = owner_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      result_d = result_q;
      gnt_d    = '0;
      rvalid_d = '0;
      case (state_q)
         IDLE: begin
            if (found) begin
               owner_d = win;
               opa_d   = sel_a;
               opb_d   = {sel_b[31] ^ sel_sub, sel_b[30:0]};
               for (int k = 0; k < N; k++) gnt_d[k] = (win == PW'(k));
               state_d = CALC;
            end
         end
         CALC: begin
            result_d = addf(opa_q, opb_q);
            for (int k = 0; k < N; k++) rvalid_d[k] = (owner_q == PW'(k));
            ptr_d   = (owner_q == PW'(N - 1)) ? '0 : owner_q + 1'b1;
            state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         owner_q  <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         result_q <= '0;
         gnt_q    <= '0;
         rvalid_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         result_q <= result_d;
         gnt_q    <= gnt_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign gnt    = gnt_q;
   assign rvalid = rvalid_q;
   assign result = result_q;
   assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_addf_arbiter.sv
// Bench for addf_arbiter: directed scenarios plus random traffic, scored against
// a real-arithmetic FP model and a round-robin grant model.
module tb_addf_arbiter;
   localparam int N = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req, sub, gnt, rvalid;
   logic [32*N-1:0] a, b;
   logic [31:0]     result;
   logic            busy;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always #5 clk = ~clk;

   addf_arbiter #(.N(N)) dut (
      .clk(clk), .rst(rst), .req(req), .sub(sub), .a(a), .b(b),
      .gnt(gnt), .rvalid(rvalid), .result(result), .busy(busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic real f2r(input logic [31:0] f);
      int  e;
      real v;
      e = (f[30:23] == 8'd0) ? 1 : int'(f[30:23]);
      v = real'({f[30:23] != 8'd0, f[22:0]}) * (2.0 ** (e - 150));
      return f[31] ? -v : v;
   endfunction

   function automatic logic [31:0] r2f(input real v_in);
      real  v, fr;
      logic s;
      int   e, m;
      v = v_in;
      if (v == 0.0) return 32'h0;
      s = (v < 0.0);
      if (s) v = -v;
      e = 150;
      while (v >= 16777216.0) begin v = v / 2.0; e++; end
      while (v < 8388608.0)   begin v = v * 2.0; e--; end
      m  = $rtoi(v);
      fr = v - real'(m);
      if (fr > 0.5 || (fr == 0.5 && m[0])) m++;
      if (m == 16777216) begin m = 8388608; e++; end
      return {s, e[7:0], m[22:0]};
   endfunction

   function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y, input logic s);
      return r2f(f2r(x) + (s ? -f2r(y) : f2r(y)));
   endfunction

   function automatic logic [31:0] rnd_fp();
      return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 135)), 23'($urandom)};
   endfunction

   // ---------------- monitor / scoreboard ----------------
   typedef struct { int k; logic [31:0] r; } sb_t;
   sb_t             sb_q[$];
   sb_t             ent;
   logic [N-1:0]    req_s, sub_s;
   logic [32*N-1:0] a_s, b_s;
   logic            rst_s;
   bit              started = 1'b0;
   int              m_cool = 0, m_ptr = 0, m_owner = 0, w;
   logic [N-1:0]    m_gnt, m_rv;
   logic [31:0]     m_res = 32'h0;

   always @(posedge clk) begin
      req_s = req; sub_s = sub; a_s = a; b_s = b; rst_s = rst;
      started = 1'b1;
      cyc++;
   end

   always @(negedge clk) begin
      if (started) begin
         m_gnt = '0;
         m_rv  = '0;
         if (rst_s) begin
            m_cool = 0; m_ptr = 0; m_res = 32'h0;
            sb_q.delete();
         end else if (m_cool == 2) begin
            m_rv   = N'(1) << m_owner;
            m_res  = (sb_q.size() != 0) ? sb_q[0].r : 32'h0;
            m_ptr  = (m_owner + 1) % N;
            m_cool = 1;
         end else if (m_cool == 1) begin
            m_cool = 0;
         end else if (req_s != '0) begin
            w = -1;
            for (int i = 0; i < N; i++)
               if (w < 0 && req_s[(m_ptr + i) % N]) w = (m_ptr + i) % N;
            m_gnt   = N'(1) << w;
            m_owner = w;
            m_cool  = 2;
            sb_q.push_back('{w, ref_add(a_s[32*w +: 32], b_s[32*w +: 32], sub_s[w])});
         end
         chk("gnt", gnt, m_gnt);
         chk("rvalid", rvalid, m_rv);
         chk("busy", busy, m_cool != 0);
         chk("result", result, m_res);
         chk("gnt_rvalid_overlap", (gnt != '0) && (rvalid != '0), 0);
         chk("gnt_onehot", $countones(gnt) <= 1, 1);
         if (rvalid != '0) begin
            if (sb_q.size() == 0) begin
               chk("sb_unexpected_rvalid", rvalid, 0);
            end else begin
               ent = sb_q.pop_front();
               chk("sb_owner", rvalid, N'(1) << ent.k);
               chk("sb_result", result, ent.r);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input int k, input logic [31:0] av, input logic [31:0] bv, input logic sv);
      a[32*k +: 32] = av;
      b[32*k +: 32] = bv;
      sub[k] = sv;
      req[k] = 1'b1;
   endtask

   task automatic wait_gnt(input string name, output logic [N-1:0] g, output int t);
      g = '0;
      t = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (gnt != '0) begin g = gnt; t = cyc; break; end
      end
      chk({name, "_gnt_seen"}, t >= 0, 1);
   endtask

   task automatic wait_rv(input int k, input logic [31:0] exp, input string name);
      int seen;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rvalid[k]) begin seen = 1; break; end
      end
      chk({name, "_rvalid_seen"}, seen, 1);
      if (seen != 0) chk(name, result, exp);
   endtask

   logic [N-1:0] g;
   int           t0, t1, tprev, grants, n1;

   initial begin
      rst = 1'b1; req = '0; sub = '0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      chk("reset_gnt", gnt, 0);
      chk("reset_rvalid", rvalid, 0);
      chk("reset_result", result, 0);
      chk("reset_busy", busy, 0);
      rst = 1'b0;

      issue(0, 32'h3F80_0000, 32'h40A0_0000, 1'b0);
      wait_gnt("single", g, t0);
      req[0] = 1'b0;
      chk("single_gnt", g, 2'b01);
      chk("single_busy_c1", busy, 1);
      wait_rv(0, 32'h40C0_0000, "single_result");
      chk("single_busy_c2", busy, 1);
      @(negedge clk);
      chk("single_busy_c3", busy, 0);

      issue(1, 32'h40A0_0000, 32'h3F80_0000, 1'b1);
      wait_gnt("sub", g, t0);
      req[1] = 1'b0;
      chk("sub_gnt", g, 2'b10);
      wait_rv(1, 32'h4080_0000, "sub_result");

      issue(0, 32'h428A_0000, 32'h40A0_0000, 1'b0);
      issue(1, 32'h4013_3333, 32'hC013_3333, 1'b0);
      wait_gnt("cont0", g, t0);
      req[0] = 1'b0;
      chk("cont_first_gnt", g, 2'b01);
      wait_rv(0, 32'h4294_0000, "cont_r0");
      wait_gnt("cont1", g, t1);
      req[1] = 1'b0;
      chk("cont_second_gnt", g, 2'b10);
      chk("cont_spacing", t1 - t0, 3);
      wait_rv(1, 32'h0000_0000, "cont_r1");

      issue(0, rnd_fp(), rnd_fp(), 1'($urandom_range(0, 1)));
      issue(1, rnd_fp(), rnd_fp(), 1'($urandom_range(0, 1)));
      grants = 0;
      tprev  = 0;
      for (int i = 0; i < 40 && grants < 6; i++) begin
         @(negedge clk);
         if (gnt != '0) begin
            chk("fair_order", gnt, (grants % 2 == 0) ? 2'b01 : 2'b10);
            if (grants > 0) chk("fair_spacing", cyc - tprev, 3);
            tprev = cyc;
            grants++;
         end
      end
      req = '0;
      chk("fair_count", grants, 6);
      repeat (3) @(negedge clk);

      // Leave ptr at 1, then abort requester 1 mid-calculation.
      issue(0, rnd_fp(), rnd_fp(), 1'b0);
      wait_gnt("pre_rst", g, t0);
      req[0] = 1'b0;
      repeat (3) @(negedge clk);
      issue(1, rnd_fp(), rnd_fp(), 1'b1);
      wait_gnt("rst_op", g, t0);
      req[1] = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rstcalc_gnt", gnt, 0);
      chk("rstcalc_rvalid", rvalid, 0);
      chk("rstcalc_result", result, 0);
      chk("rstcalc_busy", busy, 0);
      repeat (3) begin
         @(negedge clk);
         chk("rstcalc_no_rvalid", rvalid, 0);
      end
      issue(0, rnd_fp(), rnd_fp(), 1'b0);
      issue(1, rnd_fp(), rnd_fp(), 1'b0);
      wait_gnt("post_rst", g, t0);
      chk("rstcalc_first_winner", g, 2'b01);
      req = '0;
      repeat (4) @(negedge clk);

      issue(0, rnd_fp(), rnd_fp(), 1'b0);
      wait_gnt("drop", g, t0);
      req[0] = 1'b0;
      issue(1, rnd_fp(), rnd_fp(), 1'b0);
      @(negedge clk);
      req[1] = 1'b0;
      n1 = 0;
      repeat (8) begin
         @(negedge clk);
         if (gnt[1]) n1++;
      end
      chk("drop_no_gnt1", n1, 0);
      chk("drop_busy", busy, 0);

      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         for (int k = 0; k < N; k++) begin
            if (req[k] && gnt[k])
               req[k] = 1'b0;
            else if (!req[k] && $urandom_range(0, 3) == 0)
               issue(k, rnd_fp(), rnd_fp(), 1'($urandom_range(0, 1)));
            else if (req[k] && $urandom_range(0, 31) == 0)
               req[k] = 1'b0;
         end
      end
      req = '0;
      repeat (5) @(negedge clk);
      chk("final_idle", busy, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
      $fatal(1);
   end

endmodule

// File: doc/addf_arbiter.md
Name: addf_arbiter

Overview:
- Shares one combinational FP32 adder (`addf`: s = a + b) between N requesters using round-robin arbitration.
- Each request carries its own operands and an add/subtract flag. Subtract is done by inverting b's sign bit.
- Operands are latched into registers before they reach the adder, and the adder output is registered. Throughput is one operation per 3 cycles.
- Sits between the integer/control units and the float adder in the ALU.

Parameters:
- N, default 2: number of requesters. Legal range 2..4.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  per-requester request. Held high with stable operands until the matching gnt bit is seen.
- sub  input  N  per-requester op select: 0 = a+b, 1 = a-b.
- a  input  32*N  operand A; requester k uses bits [32k+31:32k].
- b  input  32*N  operand B; same packing as a.
- gnt  output  N  one-hot, one-cycle grant pulse.
- rvalid  output  N  one-hot, one-cycle result-valid pulse.
- result  output  32  shared FP32 result bus.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: state = IDLE, gnt = 0, rvalid = 0, result = 0, busy = 0, rr pointer = 0, internal operand registers = 0, owner = 0.
- FSM states: IDLE, CALC, DONE. All outputs are registered.
- IDLE, no req bit set: remain in IDLE.
- IDLE, any req bit set at edge E0:
  - Winner k = first set req bit searching upward from ptr, wrapping at N-1 -> 0.
  - Latch opa = a_k; opb = b_k with bit 31 XORed with sub_k.
  - Set owner = k and gnt = onehot(k). Next state = CALC.
- CALC, edge E1:
  - result <= addf(opa, opb) (adder driven only by opa/opb).
  - rvalid <= onehot(owner); gnt <= 0.
  - ptr <= (owner+1) mod N. Next state = DONE.
- DONE, edge E2: rvalid <= 0; next state = IDLE.
- Latency: gnt is high in the cycle after E0; rvalid and result are valid in the cycle after E1 (2 cycles after request sampling).
- The next request can be sampled at E3, so consecutive grants are 3 cycles apart.
- result holds its value until the next CALC->DONE transition.
- Requests during CALC/DONE are not sampled. Held requests stay pending and are arbitrated at the next IDLE edge.
- After a requester sees gnt, it may drop req or change operands; the latched copies are used.
- A requester that drops req before being sampled in IDLE is not served. No error is flagged.
- Simultaneous requests: only the winner gets gnt. Losers keep req high and are served in rr order.
- ptr advances only on completion.
- busy = (state != IDLE), derived from the registered state.
- Reset mid-operation, in any state:
  - Returns to the reset values on that edge.
  - No rvalid is produced for the aborted op.
  - ptr returns to 0.
- Arithmetic: sign flip only; no rounding or special-case handling beyond what addf does. NaN/inf pass through addf unchanged.
- Only one gnt bit and at most one rvalid bit are ever high. gnt and rvalid are never high in the same cycle.

Test Plan:
- Single op: after reset, req0=1, a0=0x3F800000 (1.0), b0=0x40A00000 (5.0), sub0=0 -> gnt=01 one cycle later; rvalid=01 with result=0x40C00000 (6.0) the following cycle; busy high for 2 cycles.
- Subtract: req1 only, a1=0x40A00000, b1=0x3F800000, sub1=1 -> gnt=10, then rvalid=10, result=0x40800000 (4.0).
- Contention with ptr=0: req0 = 0x428A0000+0x40A00000 and req1 = 0x40133333+0xC0133333, both held ->
  - Requester 0 first: rvalid=01, result=0x42940000 (74.0).
  - Then requester 1: gnt exactly 3 cycles after the first gnt; rvalid=10, result=0x00000000.
- Fairness: both reqs held continuously for 6 operations -> grant order 0,1,0,1,0,1; never two gnt bits high; each gnt spaced 3 cycles apart.
- Reset in CALC: assert rst for one cycle while busy ->
  - No rvalid; gnt, rvalid and result read 0.
  - Next simultaneous req0/req1 grants requester 0.
- Dropped request: pulse req1 for one cycle while FSM is in CALC, then deassert -> req1 never granted; after DONE the FSM returns to IDLE and busy = 0.
